// File: rtl/serial_adder.sv
// Bit-serial ripple-carry adder: computes a + b + cin one bit per clock, LSB first,
// with a single full-adder cell and a carry flip-flop.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset, priority over all other inputs
//   start  request an addition; a, b, cin captured when accepted (IDLE or DONE)
//   a, b   WIDTH-bit operands
//   cin    carry in
//   busy   high while bits are being processed (WIDTH cycles)
//   done   one-cycle pulse when sum/cout/ovf take their new value
//   sum    (a + b + cin) mod 2^WIDTH, held until the next done
//   cout   carry out of bit WIDTH-1
//   ovf    two's-complement overflow (carry into MSB XOR carry out of MSB)
module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_sh_q, res_sh_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic fa_s, fa_c;

  // The single full-adder cell.
  assign fa_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign fa_c = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          carry_d  = cin;
          res_sh_d = '0;
          cnt_d    = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        // Sum bits enter at the MSB so bit 0 lands at index 0 after WIDTH shifts.
        res_sh_d = {fa_s, res_sh_q[WIDTH-1:1]};
        carry_d  = fa_c;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LastBit) begin
          state_d = StDone;
          // Visible results change only here; carry_q is still the carry into the MSB.
          sum_d   = res_sh_d;
          cout_d  = fa_c;
          ovf_d   = carry_q ^ fa_c;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
